// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, frame length and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRx,
    StTxInhibit,
    StTxReq,
    StTxBits,
    StTxAck
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int unsigned FrameBits = 11;

  // Bit value that makes the total count of ones across data and parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead receive FIFO with sticky overflow flag; head reads as zero when empty.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (i_push && !w_push) r_overflow <= 1'b1;
      else if (i_pop)        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid    = (r_count != '0);
  assign o_data     = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_host_fifo.sv
// PS/2 host: filtered line inputs, receive framing into a FIFO, and host-to-device transmit.
module ps2_host_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  output logic                          ps2_clk_oe,
  output logic                          ps2_data_oe,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_write,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          tx_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_read,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_overflow
);
  localparam int unsigned FCW  = $clog2(FILTER_LEN) + 1;
  localparam int unsigned TMax = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                   : INHIBIT_CYCLES;
  localparam int unsigned TW   = $clog2(TMax) + 1;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_filt;
  logic [FCW-1:0] r_fcnt [2];
  logic           r_clk_fall;
  logic           w_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_filt     <= 2'b11;
      r_fcnt[0]  <= '0;
      r_fcnt[1]  <= '0;
      r_clk_fall <= 1'b0;
    end else begin
      r_sync1    <= {ps2_data_i, ps2_clk_i};
      r_sync2    <= r_sync1;
      r_clk_fall <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          r_fcnt[i] <= '0;
          r_filt[i] <= r_sync2[i];
          if (i == 0 && !r_sync2[i]) r_clk_fall <= 1'b1;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_data = r_filt[1];

  ps2_state_e    r_state;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [8:0]    r_tx_frame;
  logic [TW-1:0] r_timer;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_busy;
  logic          r_tx_done;
  logic          r_tx_err;
  logic          r_par_err;
  logic          r_frm_err;
  logic          r_push;
  logic          w_timeout;

  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= StIdle;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx_frame <= '0;
      r_timer    <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_err   <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_push     <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_push    <= 1'b0;
      r_timer   <= r_clk_fall ? '0 : r_timer + 1'b1;
      unique case (r_state)
        StIdle: begin
          r_timer <= '0;
          if (tx_write) begin
            r_tx_frame <= {odd_parity(tx_data), tx_data};
            r_clk_oe   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StTxInhibit;
          end else if (r_clk_fall && !w_data) begin
            r_bit_cnt <= '0;
            r_state   <= StRx;
          end
        end
        StRx: begin
          if (r_clk_fall) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt < 4'd8) begin
              r_shift <= {w_data, r_shift[7:1]};
            end else if (r_bit_cnt == 4'd8) begin
              r_par <= w_data;
            end else begin
              r_state <= StIdle;
              if (!w_data)                             r_frm_err <= 1'b1;
              else if (r_par != odd_parity(r_shift))   r_par_err <= 1'b1;
              else                                     r_push    <= 1'b1;
            end
          end else if (w_timeout) begin
            r_frm_err <= 1'b1;
            r_state   <= StIdle;
          end
        end
        StTxInhibit: begin
          // Our own clock pull-down shows up as a falling edge; it must not restart the count.
          r_timer <= r_timer + 1'b1;
          if (r_timer == TW'(INHIBIT_CYCLES - 1)) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b1;
            r_timer   <= '0;
            r_state   <= StTxReq;
          end
        end
        StTxReq, StTxBits, StTxAck: begin
          if (r_clk_fall) begin
            if (r_state == StTxReq) begin
              r_data_oe <= ~r_tx_frame[0];
              r_bit_cnt <= 4'd1;
              r_state   <= StTxBits;
            end else if (r_state == StTxBits) begin
              if (r_bit_cnt == 4'(FrameBits - 2)) begin
                r_data_oe <= 1'b0;
                r_state   <= StTxAck;
              end else begin
                r_data_oe <= ~r_tx_frame[r_bit_cnt];
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tx_done <= !w_data;
              r_tx_err  <= w_data;
              r_busy    <= 1'b0;
              r_state   <= StIdle;
            end
          end else if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_err  <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  ps2_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_rx_fifo (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_push     (r_push),
    .i_data     (r_shift),
    .i_pop      (rx_read),
    .o_data     (rx_data),
    .o_valid    (rx_valid),
    .o_count    (rx_count),
    .o_overflow (rx_overflow)
  );

  assign ps2_clk_oe    = r_clk_oe;
  assign ps2_data_oe   = r_data_oe;
  assign tx_busy       = r_busy;
  assign tx_done       = r_tx_done;
  assign tx_err        = r_tx_err;
  assign rx_parity_err = r_par_err;
  assign rx_frame_err  = r_frm_err;

endmodule

// File: tb/tb_ps2_host_fifo.sv
// Bench for ps2_host_fifo: models a PS/2 device and scoreboards received bytes.
module tb_ps2_host_fifo;
  localparam int unsigned Depth   = 8;
  localparam int unsigned FiltLen = 4;
  localparam int unsigned Inhibit = 50;
  localparam int unsigned Timeout = 2000;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_write = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read = 1'b0;
  logic [3:0] rx_count;
  logic       rx_parity_err, rx_frame_err, rx_overflow;

  always #5 CLK = ~CLK;

  // Open-drain lines with pull-ups.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_fifo #(
    .FIFO_DEPTH     (Depth),
    .FILTER_LEN     (FiltLen),
    .INHIBIT_CYCLES (Inhibit),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ps2_clk_i     (ps2_clk_i),
    .ps2_data_i    (ps2_data_i),
    .ps2_clk_oe    (ps2_clk_oe),
    .ps2_data_oe   (ps2_data_oe),
    .tx_data       (tx_data),
    .tx_write      (tx_write),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_err        (tx_err),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_read       (rx_read),
    .rx_count      (rx_count),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overflow   (rx_overflow)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_par = 0;
  int         n_frm = 0;
  int         n_done = 0;
  int         n_terr = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  // Cycles high per pulse output; a single-cycle pulse adds exactly one.
  always @(negedge CLK) begin
    if (rx_parity_err) n_par++;
    if (rx_frame_err)  n_frm++;
    if (tx_done)       n_done++;
    if (tx_err)        n_terr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return p;
  endfunction

  task automatic send_bit(input logic b);
    dev_data = b;
    repeat (10) @(negedge CLK);
    dev_clk = 1'b0;
    repeat (20) @(negedge CLK);
    dev_clk = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    dev_data = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    if (exp_q.size() < Depth) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    check_eq({tag, "_valid"}, rx_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check_eq({tag, "_data"}, rx_data, exp);
    end
    rx_read = 1'b1;
    @(negedge CLK);
    rx_read = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic tx_transfer(input logic [7:0] d, input logic ack, input logic retry);
    int         n, cyc, done0, err0;
    logic [9:0] got, want;
    done0 = n_done;
    err0  = n_terr;
    want  = {1'b1, odd_par(d), d};
    got   = '0;
    tx_data = d;
    tx_write = 1'b1;
    @(negedge CLK);
    tx_write = 1'b0;
    check_eq("tx_busy_set", tx_busy, 1'b1);
    n = 0;
    cyc = 0;
    if (retry) begin
      tx_data = 8'h00;
      tx_write = 1'b1;
      n = ps2_clk_oe ? 1 : 0;
      @(negedge CLK);
      tx_write = 1'b0;
    end
    while (!ps2_data_oe && cyc < 1000) begin
      if (ps2_clk_oe) n++;
      cyc++;
      @(negedge CLK);
    end
    check_eq("inhibit_len", n, Inhibit);
    check_eq("tx_start_bit", ps2_data_i, 1'b0);
    for (int k = 0; k < 11; k++) begin
      if (k == 10 && !ack) dev_data = 1'b0;
      repeat (10) @(negedge CLK);
      dev_clk = 1'b0;
      repeat (20) @(negedge CLK);
      if (k < 10) got[k] = ps2_data_i;
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    repeat (10) @(negedge CLK);
    for (int k = 0; k < 10; k++) check_eq($sformatf("tx_bit%0d", k), got[k], want[k]);
    check_eq("tx_done_pulses", n_done - done0, ack ? 0 : 1);
    check_eq("tx_err_pulses", n_terr - err0, ack ? 1 : 0);
    check_eq("tx_busy_clear", tx_busy, 1'b0);
  endtask

  initial begin
    int base, cyc;
    repeat (3) @(negedge CLK);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_rx_count", rx_count, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check_eq("rst_tx_busy", tx_busy, 1'b0);
    check_eq("rst_overflow", rx_overflow, 1'b0);
    RST = 1'b1;
    repeat (10) @(negedge CLK);

    // Single good frame.
    send_frame(8'hAA, odd_par(8'hAA), 1'b1);
    expect_byte(8'hAA);
    check_eq("aa_count", rx_count, 1);
    pop_check("aa");
    check_eq("aa_count_after", rx_count, 0);

    // Wrong parity and missing stop bit both discard the byte.
    base = n_par;
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (5) @(negedge CLK);
    check_eq("par_err_pulses", n_par - base, 1);
    check_eq("par_err_valid", rx_valid, 1'b0);
    base = n_frm;
    send_frame(8'h12, odd_par(8'h12), 1'b0);
    check_eq("stop_err_pulses", n_frm - base, 1);
    check_eq("stop_err_valid", rx_valid, 1'b0);

    // Overfill the FIFO by one.
    for (int i = 1; i <= Depth + 1; i++) begin
      send_frame(8'(i), odd_par(8'(i)), 1'b1);
      expect_byte(8'(i));
    end
    check_eq("full_count", rx_count, Depth);
    check_eq("full_overflow", rx_overflow, exp_ovf);
    pop_check("ovf_head");
    check_eq("ovf_cleared", rx_overflow, exp_ovf);
    while (exp_q.size() > 0 && rx_valid) pop_check("drain");
    check_eq("drained_count", rx_count, 0);

    // Host to device transfers.
    tx_transfer(8'hF4, 1'b0, 1'b0);
    tx_transfer(8'hFF, 1'b1, 1'b1);
    repeat (100) @(negedge CLK);
    check_eq("retry_ignored_busy", tx_busy, 1'b0);

    // Device stops clocking mid-frame.
    base = n_frm;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    cyc = 0;
    while (n_frm == base && cyc < Timeout + 500) begin
      cyc++;
      @(negedge CLK);
    end
    check_eq("timeout_pulse", n_frm - base, 1);
    check_eq("timeout_window", ((cyc + 30 >= Timeout) && (cyc + 30 <= Timeout + 30)), 1'b1);
    check_eq("timeout_valid", rx_valid, 1'b0);

    // Reset in the middle of a transmit.
    base = n_terr;
    tx_data = 8'h5A;
    tx_write = 1'b1;
    @(negedge CLK);
    tx_write = 1'b0;
    cyc = 0;
    while (!ps2_data_oe && cyc < 1000) begin
      cyc++;
      @(negedge CLK);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (10) @(negedge CLK);
      dev_clk = 1'b0;
      repeat (20) @(negedge CLK);
      if (k < 2) dev_clk = 1'b1;
    end
    check_eq("pre_rst_data_oe", ps2_data_oe, 1'b1);
    RST = 1'b0;
    #1;
    check_eq("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check_eq("rst_mid_busy", tx_busy, 1'b0);
    dev_clk = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    check_eq("rst_mid_no_err", n_terr - base, 0);
    send_frame(8'h3C, odd_par(8'h3C), 1'b1);
    expect_byte(8'h3C);
    pop_check("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_fifo.md
PS2_HOST_FIFO -- requirements
Module: ps2_host_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO depth in bytes (power of 2, >=2).
REQ-002 SHALL have parameter FILTER_LEN, default 4, CLK cycles a PS/2 line must hold a new level before it is accepted.
REQ-003 SHALL have parameter INHIBIT_CYCLES, default 5000, CLK cycles the host holds ps2_clk low before a transmit (100 us at 50 MHz).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, maximum CLK cycles allowed between device clock falling edges mid-frame.
REQ-005 SHALL have port CLK  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports ps2_clk_i / ps2_data_i  in  1  raw line levels, asynchronous.
REQ-008 SHALL have ports ps2_clk_oe / ps2_data_oe  out  1  open-drain pull-low enables; 1 = drive line low.
REQ-009 SHALL have ports tx_data  in  8  command byte, and tx_write  in  1  single-cycle transmit request.
REQ-010 SHALL have ports tx_busy  out  1, tx_done  out  1  pulse on acknowledged transmit, and tx_err  out  1  pulse on missing ACK or timeout.
REQ-011 SHALL have ports rx_data  out  8  FIFO head, rx_valid  out  1  FIFO not empty, and rx_read  in  1  pop.
REQ-012 SHALL have ports rx_count  out  $clog2(FIFO_DEPTH)+1, rx_parity_err  out  1  pulse, rx_frame_err  out  1  pulse, and rx_overflow  out  1  sticky.

Function
REQ-013 SHALL pass each input through a 2-flop synchronizer and then a FILTER_LEN glitch filter; a device clock edge is a filtered 1->0 transition of ps2_clk.
REQ-014 SHALL implement states IDLE, RX, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK.
REQ-015 IDLE->RX on a falling edge with filtered data 0 (start bit); a falling edge with data 1 in IDLE SHALL be ignored.
REQ-016 RX SHALL sample on 10 further falling edges: 8 data bits LSB first, odd parity, stop.
REQ-017 A good frame SHALL be written to the FIFO on the cycle after the stop sample; a parity mismatch SHALL pulse rx_parity_err and discard the byte; stop=0 SHALL pulse rx_frame_err and discard the byte.
REQ-018 A push when FIFO is full SHALL drop the new byte and set rx_overflow; rx_overflow SHALL clear only on reset or on an rx_read.
REQ-019 FIFO SHALL be show-ahead: rx_data is valid whenever rx_valid=1; rx_read with rx_valid=0 SHALL be ignored; simultaneous push and pop SHALL leave rx_count unchanged.
REQ-020 tx_write SHALL be accepted only in IDLE; when it is accepted, the module SHALL latch tx_data and enter TX_INHIBIT, with tx_busy=1 from the next cycle until return to IDLE; tx_write outside IDLE SHALL be ignored.
REQ-021 TX_INHIBIT SHALL assert ps2_clk_oe for INHIBIT_CYCLES, then assert ps2_data_oe and release clock (TX_REQ).
REQ-022 TX_BITS SHALL update ps2_data_oe after each device falling edge: 8 data bits LSB first, odd parity, then release (stop).
REQ-023 TX_ACK SHALL sample data on the next falling edge; 0 -> tx_done pulse, 1 -> tx_err pulse; both SHALL return to IDLE.
REQ-024 In RX, TX_REQ, TX_BITS or TX_ACK, TIMEOUT_CYCLES without a falling edge SHALL release both lines and return to IDLE, pulsing rx_frame_err (RX) or tx_err (TX).
REQ-025 Every status pulse SHALL be exactly one CLK cycle wide.

Reset
REQ-026 RST=0 SHALL immediately force IDLE, clear the FIFO, and drive all outputs to 0, including both oe outputs (lines released); rx_count SHALL be 0.
REQ-027 Reset mid-frame SHALL abandon the frame without a pulse; the first start bit after release SHALL be received normally.

Structure
REQ-028 The state encoding, the frame bit count (11) and the odd-parity function SHALL live in a shared package ps2_pkg.
REQ-029 The receive FIFO SHALL be a sub-module ps2_rx_fifo (parametrised by depth and width 8).

Verification
REQ-030 Device frame 0xAA with parity 1 -> rx_valid=1, rx_data=0xAA, rx_count=1; rx_read -> rx_count=0.
REQ-031 Frame 0x55 with parity 0 -> exactly one rx_parity_err pulse, rx_valid stays 0.
REQ-032 FIFO_DEPTH+1 frames (0x01..0x09, depth 8) with no reads -> rx_count=8, rx_overflow=1, head=0x01; one rx_read -> rx_overflow=0.
REQ-033 tx_write with tx_data=0xF4 and device ACK=0 -> clk held low INHIBIT_CYCLES, bits 0,0,1,0,1,1,1,1, parity 0, then tx_done pulse and tx_busy=0.
REQ-034 tx_write with tx_data=0xFF and device ACK=1 -> tx_err pulse; tx_write repeated while tx_busy=1 -> ignored.
REQ-035 Device stops clocking after 4 bits -> rx_frame_err after TIMEOUT_CYCLES; RST=0 mid-TX_BITS -> both oe=0 at once.
